parking_sensor_frontend: RTL and testbench
==========================================

# parking_sensor_frontend

Conditions the raw entry and exit beam sensors and the exit-slot selector before they reach the parking state machine. Each raw input is debounced, and each qualified rising edge becomes a pending event. Pending events are issued as single-cycle `entry_sensor` / `exit_sensor` pulses, at most one per cycle, exit first, with an enforced gate hold-off between pulses. The block sits directly upstream of the occupancy FSM and drives its `entry_sensor`, `exit_sensor` and `exit_location` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive sampling edges a raw input must differ from its debounced state before the state toggles. Must be ≥2.
- `GAP_CYCLES`, 3: minimum idle cycles after any issued pulse before the next pulse. Must be ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `entry_raw` in 1: raw entry beam, active-high, unsynchronised.
- `exit_raw` in 1: raw exit beam, active-high, unsynchronised.
- `exit_slot_raw` in 2: slot index reported by the exit reader.
- `entry_sensor` out 1: one-cycle entry event pulse.
- `exit_sensor` out 1: one-cycle exit event pulse.
- `exit_location` out 2: slot of the issued exit; updated only on exit issue, held otherwise.
- `pending_entry` out 1: an entry event is waiting to be issued.
- `pending_exit` out 1: an exit event is waiting to be issued.
- `dropped` out 1: one-cycle pulse when a new edge arrives while that event type's pending flag is already set.

## Operation
- Reset values: all outputs 0, debounced states 0, debounce counters 0, captured slot 0, FSM in IDLE, gap counter 0.
- Debounce, per sensor: counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - Input equal to debounced state: counter clears.
  - Input differs, counter == `DEBOUNCE_CYCLES-1`: state takes the input value and counter clears.
  - Input differs otherwise: counter increments.
- A glitch shorter than `DEBOUNCE_CYCLES` edges never toggles the state. Falling transitions are debounced identically but produce no event.
- Rising debounced entry (0→1): sets `pending_entry` on the same edge.
- Rising debounced exit (0→1): sets `pending_exit` and captures `exit_slot_raw` (post-sync value) into the slot register on the same edge.
- Edge while the same pending flag is already 1 and not being cleared that edge:
  - flag unchanged, captured slot not overwritten;
  - `dropped`=1 for one cycle.
- Edge on the same edge its pending flag is cleared by issue: flag stays 1, slot is recaptured, no `dropped`.
- Issue FSM states:
  - IDLE: if `pending_exit`, next edge asserts `exit_sensor`, loads `exit_location` from the slot register, clears `pending_exit`, goes to HOLDOFF. Else if `pending_entry`, next edge asserts `entry_sensor`, clears `pending_entry`, goes to HOLDOFF. Else stays in IDLE.
  - HOLDOFF: pulse outputs are 0. Stays for `GAP_CYCLES` cycles after the pulse cycle, then returns to IDLE.
- `entry_sensor` and `exit_sensor` are never high in the same cycle. Each pulse is exactly one cycle wide.
- Raw input held high across reset release: debounced state starts at 0, so one event is generated after `DEBOUNCE_CYCLES` edges.

## Timing
- All outputs are registered.
- Sensor latency:
  - The first edge sampling the new raw level is edge 1; debounced state toggles and pending sets at edge `DEBOUNCE_CYCLES`.
  - With the block in IDLE, the pulse is asserted at edge `DEBOUNCE_CYCLES+1` and deasserted at the following edge.
- Pulse spacing: while an event is pending, the next pulse edge equals the previous pulse edge + `GAP_CYCLES` + 1.
- `exit_location` is valid in the same cycle as `exit_sensor` and remains stable until the next exit issue.
- `pending_*` reflects the registered flag; it is 1 from the set edge through the issue edge.
- Reset asserted mid-operation: all registers clear immediately, pending events are discarded, and no pulse appears after deassertion unless raw inputs re-qualify.

## Configuration
- `PARKING_SENSOR_SYNC_EN` defined:
  - `entry_raw`, `exit_raw` and `exit_slot_raw` each pass through a two-flop synchronizer, reset to 0, before debounce;
  - every latency above increases by 2 edges.
- Undefined: raw inputs feed debounce directly. Inputs must then be synchronous to `clk`.

## Test plan
All cases use defaults `DEBOUNCE_CYCLES`=4 and `GAP_CYCLES`=3, with the macro undefined.
- Entry latency: `entry_raw` rises before edge 1 and stays high → `pending_entry`=1 after edge 4; `entry_sensor`=1 for exactly the cycle after edge 5; `pending_entry`=0.
- Glitch rejection: `exit_raw` high for 3 edges, then low → no `exit_sensor`, `pending_exit` stays 0, `dropped` stays 0.
- Simultaneous events: both raw inputs rise together, `exit_slot_raw`=2'b10 → `exit_sensor` after edge 5 with `exit_location`=2'b10; `entry_sensor` after edge 9; never both high.
- Dropped event: second exit edge (release, then re-press 4 edges) while `pending_exit`=1 during HOLDOFF, slot changed to 2'b01 → `dropped` pulses once; issued `exit_location` keeps the original value.
- Reset mid-operation: assert `reset` while `pending_entry`=1 → all outputs 0 immediately; no `entry_sensor` after release with `entry_raw` low.
- Back-to-back spacing: three entry events queued one at a time → pulse edges exactly 4 apart.

Source files
------------

// File: rtl/parking_sensor_frontend.sv
// Debounces the entry/exit beams and turns qualified rising edges into spaced entry/exit pulses, exit first.
// Optional two-flop input synchronizers are enabled by defining PARKING_SENSOR_SYNC_EN.
module parking_sensor_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_raw,
  input  logic       exit_raw,
  input  logic [1:0] exit_slot_raw,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exit_location,
  output logic       pending_entry,
  output logic       pending_exit,
  output logic       dropped
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic {IDLE, HOLDOFF} state_t;

  logic       entry_s, exit_s;
  logic [1:0] exit_slot_s;

`ifdef PARKING_SENSOR_SYNC_EN
  logic [1:0] entry_sync_q, exit_sync_q;
  logic [1:0] slot_meta_q, slot_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_sync_q <= '0;
      exit_sync_q  <= '0;
      slot_meta_q  <= '0;
      slot_sync_q  <= '0;
    end else begin
      entry_sync_q <= {entry_sync_q[0], entry_raw};
      exit_sync_q  <= {exit_sync_q[0], exit_raw};
      slot_meta_q  <= exit_slot_raw;
      slot_sync_q  <= slot_meta_q;
    end
  end

  assign entry_s     = entry_sync_q[1];
  assign exit_s      = exit_sync_q[1];
  assign exit_slot_s = slot_sync_q;
`else
  assign entry_s     = entry_raw;
  assign exit_s      = exit_raw;
  assign exit_slot_s = exit_slot_raw;
`endif

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            deb_entry_q, deb_entry_d, deb_exit_q, deb_exit_d;
  logic [CW-1:0]   cnt_entry_q, cnt_entry_d, cnt_exit_q, cnt_exit_d;
  logic [1:0]      slot_q, slot_d, loc_q, loc_d;
  logic            pend_entry_q, pend_entry_d, pend_exit_q, pend_exit_d;
  logic            entry_pulse_q, entry_pulse_d, exit_pulse_q, exit_pulse_d;
  logic            dropped_q, dropped_d;
  logic            rise_entry, rise_exit, issue_entry, issue_exit;

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    deb_entry_d   = deb_entry_q;
    deb_exit_d    = deb_exit_q;
    cnt_entry_d   = cnt_entry_q;
    cnt_exit_d    = cnt_exit_q;
    slot_d        = slot_q;
    loc_d         = loc_q;
    pend_entry_d  = pend_entry_q;
    pend_exit_d   = pend_exit_q;
    entry_pulse_d = 1'b0;
    exit_pulse_d  = 1'b0;
    dropped_d     = 1'b0;
    rise_entry    = 1'b0;
    rise_exit     = 1'b0;
    issue_entry   = 1'b0;
    issue_exit    = 1'b0;

    if (entry_s == deb_entry_q) begin
      cnt_entry_d = '0;
    end else if (cnt_entry_q == CNT_LAST) begin
      deb_entry_d = entry_s;
      cnt_entry_d = '0;
      rise_entry  = entry_s;
    end else begin
      cnt_entry_d = cnt_entry_q + 1'b1;
    end

    if (exit_s == deb_exit_q) begin
      cnt_exit_d = '0;
    end else if (cnt_exit_q == CNT_LAST) begin
      deb_exit_d = exit_s;
      cnt_exit_d = '0;
      rise_exit  = exit_s;
    end else begin
      cnt_exit_d = cnt_exit_q + 1'b1;
    end

    // gap_q counts HOLDOFF cycles so the next issue lands GAP_CYCLES+1 edges after the last
    case (state_q)
      IDLE: begin
        if (pend_exit_q) begin
          issue_exit   = 1'b1;
          exit_pulse_d = 1'b1;
          loc_d        = slot_q;
          state_d      = HOLDOFF;
          gap_d        = '0;
        end else if (pend_entry_q) begin
          issue_entry   = 1'b1;
          entry_pulse_d = 1'b1;
          state_d       = HOLDOFF;
          gap_d         = '0;
        end
      end
      HOLDOFF: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue_exit)  pend_exit_d  = 1'b0;
    if (issue_entry) pend_entry_d = 1'b0;

    if (rise_exit) begin
      if (pend_exit_q && !issue_exit) begin
        dropped_d = 1'b1;
      end else begin
        pend_exit_d = 1'b1;
        slot_d      = exit_slot_s;
      end
    end
    if (rise_entry) begin
      if (pend_entry_q && !issue_entry) dropped_d    = 1'b1;
      else                              pend_entry_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      deb_entry_q   <= 1'b0;
      deb_exit_q    <= 1'b0;
      cnt_entry_q   <= '0;
      cnt_exit_q    <= '0;
      slot_q        <= '0;
      loc_q         <= '0;
      pend_entry_q  <= 1'b0;
      pend_exit_q   <= 1'b0;
      entry_pulse_q <= 1'b0;
      exit_pulse_q  <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      deb_entry_q   <= deb_entry_d;
      deb_exit_q    <= deb_exit_d;
      cnt_entry_q   <= cnt_entry_d;
      cnt_exit_q    <= cnt_exit_d;
      slot_q        <= slot_d;
      loc_q         <= loc_d;
      pend_entry_q  <= pend_entry_d;
      pend_exit_q   <= pend_exit_d;
      entry_pulse_q <= entry_pulse_d;
      exit_pulse_q  <= exit_pulse_d;
      dropped_q     <= dropped_d;
    end
  end

  assign entry_sensor  = entry_pulse_q;
  assign exit_sensor   = exit_pulse_q;
  assign exit_location = loc_q;
  assign pending_entry = pend_entry_q;
  assign pending_exit  = pend_exit_q;
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_parking_sensor_frontend.sv
// Bench for parking_sensor_frontend: directed scenarios plus random beams against an edge-counting reference model.
// A second instance with a long gap makes a dropped exit reachable.
module tb_parking_sensor_frontend;

  localparam int D  = 4;
  localparam int G  = 3;
  localparam int GL = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_raw = 1'b0;
  logic       exit_raw = 1'b0;
  logic [1:0] exit_slot_raw = 2'b00;

  logic       entry_sensor, exit_sensor, pending_entry, pending_exit, dropped;
  logic [1:0] exit_location;
  logic       g_entry_sensor, g_exit_sensor, g_pending_entry, g_pending_exit, g_dropped;
  logic [1:0] g_exit_location;

  always #5 clk = ~clk;

  parking_sensor_frontend #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .entry_raw(entry_raw), .exit_raw(exit_raw),
    .exit_slot_raw(exit_slot_raw), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .exit_location(exit_location), .pending_entry(pending_entry), .pending_exit(pending_exit),
    .dropped(dropped)
  );

  parking_sensor_frontend #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(GL)) dut_g (
    .clk(clk), .reset(reset), .entry_raw(entry_raw), .exit_raw(exit_raw),
    .exit_slot_raw(exit_slot_raw), .entry_sensor(g_entry_sensor), .exit_sensor(g_exit_sensor),
    .exit_location(g_exit_location), .pending_entry(g_pending_entry), .pending_exit(g_pending_exit),
    .dropped(g_dropped)
  );

  int checks = 0;
  int failures = 0;
  int ecount = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  // Reference model: integer run lengths and edge numbers, no state machine.
  int       m_run_e, m_run_x, m_n, m_last;
  bit       m_deb_e, m_deb_x, m_pe, m_px, m_es, m_xs, m_dr;
  bit [1:0] m_slot, m_loc;

  task automatic model_reset();
    m_run_e = 0; m_run_x = 0; m_n = 0; m_last = -1000;
    m_deb_e = 0; m_deb_x = 0; m_pe = 0; m_px = 0;
    m_es = 0; m_xs = 0; m_dr = 0; m_slot = 0; m_loc = 0;
  endtask

  task automatic model_edge(input bit e, input bit x, input bit [1:0] s);
    bit rise_e, rise_x, iss_e, iss_x, ready;
    m_n++;
    rise_e = 0;
    rise_x = 0;
    if (e != m_deb_e) begin
      m_run_e++;
      if (m_run_e == D) begin m_deb_e = e; m_run_e = 0; rise_e = e; end
    end else m_run_e = 0;
    if (x != m_deb_x) begin
      m_run_x++;
      if (m_run_x == D) begin m_deb_x = x; m_run_x = 0; rise_x = x; end
    end else m_run_x = 0;
    ready = (m_n - m_last) >= G + 1;
    iss_x = ready && m_px;
    iss_e = ready && !m_px && m_pe;
    m_xs = iss_x;
    m_es = iss_e;
    if (iss_x || iss_e) m_last = m_n;
    if (iss_x) m_loc = m_slot;
    m_dr = (rise_e && m_pe && !iss_e) || (rise_x && m_px && !iss_x);
    if (iss_x) m_px = 0;
    if (iss_e) m_pe = 0;
    if (rise_x && !m_px) begin m_px = 1; m_slot = s; end
    if (rise_e) m_pe = 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge(entry_raw, exit_raw, exit_slot_raw);
    ecount++;
    @(negedge clk);
    chk("outs", {25'd0, entry_sensor, exit_sensor, exit_location, pending_entry, pending_exit, dropped},
        {25'd0, m_es, m_xs, m_loc, m_pe, m_px, m_dr});
    chk("excl", {31'd0, entry_sensor & exit_sensor}, 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    entry_raw = 1'b0;
    exit_raw = 1'b0;
    exit_slot_raw = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ecount = 0;
  endtask

  int pulses[$];
  int npulse;
  int e_hold, x_hold;

  initial begin
    model_reset();
    do_reset();
    chk("rst_state", {26'd0, entry_sensor, exit_sensor, exit_location, pending_entry, pending_exit}, 32'd0);

    // Entry latency
    entry_raw = 1'b1;
    steps(3);
    chk("lat_pend_e3", {31'd0, pending_entry}, 32'd0);
    step();
    chk("lat_pend_e4", {31'd0, pending_entry}, 32'd1);
    step();
    chk("lat_pulse5", {31'd0, entry_sensor}, 32'd1);
    chk("lat_pend_e5", {31'd0, pending_entry}, 32'd0);
    step();
    chk("lat_pulse6", {31'd0, entry_sensor}, 32'd0);

    // Glitch rejection
    do_reset();
    exit_raw = 1'b1;
    steps(3);
    exit_raw = 1'b0;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      npulse += int'(exit_sensor) + int'(pending_exit) + int'(dropped);
    end
    chk("glitch", npulse, 0);

    // Simultaneous events, then a re-pressed entry for back-to-back spacing
    do_reset();
    pulses.delete();
    entry_raw = 1'b1;
    exit_raw = 1'b1;
    exit_slot_raw = 2'b10;
    steps(4);
    chk("sim_pend", {30'd0, pending_entry, pending_exit}, 32'd3);
    entry_raw = 1'b0;
    exit_slot_raw = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ecount == 5) chk("sim_exit_loc", {29'd0, exit_sensor, exit_location}, {29'd0, 1'b1, 2'b10});
      if (ecount == 9) chk("sim_entry9", {30'd0, entry_sensor, exit_sensor}, 32'd2);
      if (ecount == 8) entry_raw = 1'b1;
      if (entry_sensor || exit_sensor) pulses.push_back(ecount);
    end
    chk("b2b_count", pulses.size(), 3);
    chk("b2b_p0", (pulses.size() > 0) ? pulses[0] : -1, 5);
    chk("b2b_p1", (pulses.size() > 1) ? pulses[1] : -1, 9);
    chk("b2b_p2", (pulses.size() > 2) ? pulses[2] : -1, 13);

    // Dropped exit on the long-gap instance
    do_reset();
    exit_raw = 1'b1;
    exit_slot_raw = 2'b10;
    steps(5);
    chk("drop_first", {29'd0, g_exit_sensor, g_exit_location}, {29'd0, 1'b1, 2'b10});
    exit_raw = 1'b0;
    steps(4);
    exit_raw = 1'b1;
    exit_slot_raw = 2'b01;
    steps(4);
    chk("drop_pend13", {30'd0, g_pending_exit, g_dropped}, 32'd2);
    exit_raw = 1'b0;
    steps(4);
    exit_raw = 1'b1;
    exit_slot_raw = 2'b11;
    steps(4);
    chk("drop_pulse21", {31'd0, g_dropped}, 32'd1);
    step();
    chk("drop_clear22", {31'd0, g_dropped}, 32'd0);
    steps(3);
    chk("drop_wait25", {31'd0, g_exit_sensor}, 32'd0);
    step();
    chk("drop_issue26", {29'd0, g_exit_sensor, g_exit_location}, {29'd0, 1'b1, 2'b01});

    // Reset mid-operation
    do_reset();
    entry_raw = 1'b1;
    steps(4);
    chk("mid_pend", {31'd0, pending_entry}, 32'd1);
    #2;
    reset = 1'b1;
    entry_raw = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_outs", {26'd0, entry_sensor, exit_sensor, exit_location, pending_entry, pending_exit}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ecount = 0;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      npulse += int'(entry_sensor);
    end
    chk("mid_no_pulse", npulse, 0);

    // Random beams with occasional resets
    do_reset();
    e_hold = 0;
    x_hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if (e_hold == 0) begin
        entry_raw = $urandom_range(0, 1) == 1;
        e_hold = $urandom_range(1, 10);
      end
      if (x_hold == 0) begin
        exit_raw = $urandom_range(0, 1) == 1;
        x_hold = $urandom_range(1, 10);
      end
      exit_slot_raw = 2'($urandom_range(0, 3));
      e_hold--;
      x_hold--;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
